pp_muladd_rr_sched: RTL

Round-robin scheduler that shares one 8x13+15 unsigned multiply-add unit (`pp_pipeline_accel_mac_muladd_8ns_13ns_15ns_21_4_1`, instantiated internally) between `NREQ` requesters in the pre-processing pipeline. It accepts operand triples over per-requester valid/ready handshakes and issues at most one per cycle. It tags each issued operation with its requester index through the pipeline and returns results on a single valid/ready output stream. When the output is back-pressured it stalls the whole unit via the unit's `ce`.

---
 rtl/pp_muladd_rr_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pp_muladd_rr_sched.sv
// pp_muladd_rr_sched
//   Round-robin scheduler that shares one 8x13+15 unsigned multiply-add unit
//   between NREQ requesters. At most one operand triple is issued per cycle.
//   Each issued operation carries its requester index through a four-stage tag
//   pipeline that runs alongside the arithmetic. Results leave on one
//   valid/ready stream. Output back-pressure freezes the whole unit through ce.
//
//   Optional feature macro: PP_MULADD_SCHED_PERF_EN
//     When defined, adds the saturating counters issue_cnt and stall_cnt.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   req_valid  per-requester operand valid             [NREQ]
//   req_ready  per-requester accept, one-hot or zero   [NREQ]
//   req_in0    multiplicands, 8 bits per requester     [NREQ*8]
//   req_in1    multipliers, 13 bits per requester      [NREQ*13]
//   req_in2    addends, 15 bits per requester          [NREQ*15]
//   out_valid  result valid
//   out_ready  downstream accept
//   out_data   (in0*in1+in2) mod 2^21, 0 when out_valid=0
//   out_id     requester index of out_data
//   issue_cnt  accepted operations (PERF_EN only)
//   stall_cnt  cycles with the unit frozen (PERF_EN only)

// Multiply-add unit with three register stages. dout appears three
// ce-enabled edges after din is presented. The data path has no reset
// because the scheduler's tag valids mask its contents.
module pp_pipeline_accel_mac_muladd_8ns_13ns_15ns_21_4_1 (
   input  logic        clk,
   input  logic        ce,
   input  logic [7:0]  din0,
   input  logic [12:0] din1,
   input  logic [14:0] din2,
   output logic [20:0] dout
);
   logic [7:0]  a_q;
   logic [12:0] b_q;
   logic [14:0] c_q;
   logic [14:0] c2_q;
   logic [20:0] m_q;
   logic [20:0] p_q;

   // The operands are zero-extended to 21 bits so that the product
   // wraps modulo 2^21 and no high bits are lost to operand sizing.
   always_ff @(posedge clk) begin
      if (ce) begin
         a_q  <= din0;
         b_q  <= din1;
         c_q  <= din2;
         m_q  <= {13'b0, a_q} * {8'b0, b_q};
         c2_q <= c_q;
         p_q  <= m_q + {6'b0, c2_q};
      end
   end

   assign dout = p_q;
endmodule

module pp_muladd_rr_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*8-1:0]  req_in0,
   input  logic [NREQ*13-1:0] req_in1,
   input  logic [NREQ*15-1:0] req_in2,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [20:0]        out_data,
   output logic [IDW-1:0]     out_id
`ifdef PP_MULADD_SCHED_PERF_EN
   ,
   output logic [31:0]        issue_cnt,
   output logic [31:0]        stall_cnt
`endif
);

   logic            adv;
   logic            grant_any;
   logic [IDW-1:0]  grant_id;
   logic [IDW-1:0]  sel;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [7:0]      iss_in0_q;
   logic [12:0]     iss_in1_q;
   logic [14:0]     iss_in2_q;
   logic [3:0]      vld_q;
   logic [IDW-1:0]  id_q [4];
   logic [20:0]     mac_dout;

   assign adv = !out_valid || out_ready;

   // The search runs from the farthest candidate down to ptr. The last hit
   // therefore wins, which is the first valid requester at or after ptr.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      sel       = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         sel = IDW'((int'(ptr_q) + k) % NREQ);
         if (adv && req_valid[sel]) begin
            grant_any = 1'b1;
            grant_id  = sel;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant_any && !reset) req_ready[grant_id] = 1'b1;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_any) ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   // The operand register is captured on every advancing edge, even when
   // nothing is granted. An ungranted capture is harmless because tag stage 0
   // then carries valid=0.
   always_ff @(posedge clk) begin
      if (adv) begin
         iss_in0_q <= req_in0[grant_id*8 +: 8];
         iss_in1_q <= req_in1[grant_id*13 +: 13];
         iss_in2_q <= req_in2[grant_id*15 +: 15];
      end
   end

   pp_pipeline_accel_mac_muladd_8ns_13ns_15ns_21_4_1 u_mac (
      .clk  (clk),
      .ce   (adv),
      .din0 (iss_in0_q),
      .din1 (iss_in1_q),
      .din2 (iss_in2_q),
      .dout (mac_dout)
   );

   // Tag stage 0 lines up with the operand register, and stage 3 lines up
   // with the dout of the multiply-add unit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         for (int s = 0; s < 4; s++) id_q[s] <= '0;
      end else if (adv) begin
         vld_q   <= {vld_q[2:0], grant_any};
         id_q[0] <= grant_id;
         id_q[1] <= id_q[0];
         id_q[2] <= id_q[1];
         id_q[3] <= id_q[2];
      end
   end

   assign out_valid = vld_q[3];
   assign out_id    = id_q[3];
   assign out_data  = out_valid ? mac_dout : 21'd0;

`ifdef PP_MULADD_SCHED_PERF_EN
   logic [31:0] issue_cnt_q, stall_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (grant_any && issue_cnt_q != 32'hFFFF_FFFF) issue_cnt_q <= issue_cnt_q + 32'd1;
         if (!adv && stall_cnt_q != 32'hFFFF_FFFF)      stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign issue_cnt = issue_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule
